sc_tx_port_arb_n: RTL and testbench
===================================

// Module: sc_tx_port_arb_n
// PURPOSE
//  N-way arbiter and mux for the slave-controller TX port (SCTxPort).
//  Grants one requester at a time (sendPacket, directCntl, future SOF/test sources).
//  Steers that requester's data/cntl/WEn onto the shared port.
//  Supports fixed-priority or round-robin selection.
// PARAMETERS
//  NUM_REQ   3  number of requesters, 2..8; index 0 = highest fixed priority
//  DATA_W    8  width of data and cntl buses
//  ARB_MODE  0  0 = fixed priority (lowest index wins); 1 = round-robin
//  HOLD_MAX  64 grant-hold cycle limit; used only with SC_TX_ARB_HOLD_TIMEOUT_EN
// PORTS
//  clk             in   1               single clock, rising edge
//  rst             in   1               asynchronous, active-low reset
//  req             in   NUM_REQ         per-requester request, level, held until done
//  wen             in   NUM_REQ         per-requester write enable
//  data            in   NUM_REQ*DATA_W  packed data; slice i = requester i
//  cntl            in   NUM_REQ*DATA_W  packed cntl; slice i = requester i
//  gnt             out  NUM_REQ         registered one-hot grant
//  SCTxPortRdyIn   in   1               ready from TX port
//  SCTxPortRdyOut  out  1               = SCTxPortRdyIn (combinational pass-through)
//  SCTxPortWEnable out  1               wen[owner] & busy
//  SCTxPortData    out  DATA_W          data[owner]
//  SCTxPortCntl    out  DATA_W          cntl[owner]
//  hold_err        out  1               1-cycle timeout pulse; tied 0 without macro
// BEHAVIOUR
//  Reset values: gnt = 0, owner = 0, rr_ptr = 0, hold_err = 0, state = ST_START.
//  States:
//   ST_START: exits to ST_IDLE one cycle after reset release. Requests are ignored here.
//   ST_IDLE: on any req, pick winner w; next cycle state = ST_BUSY, gnt = onehot(w), owner = w.
//   ST_BUSY: when req[owner] = 0, next cycle gnt = 0 and state = ST_IDLE.
//  Latency:
//   req to gnt: 1 cycle.
//   Release to gnt low: 1 cycle.
//   One mandatory idle cycle between grants. Back-to-back grants are never issued.
//  Selection:
//   Fixed mode: lowest set index of req.
//   RR mode: first set req at or after rr_ptr, modulo NUM_REQ.
//   RR mode: rr_ptr <= w+1 (wraps NUM_REQ-1 -> 0) when a grant is issued.
//  Mux:
//   owner is registered. It holds its last value while idle.
//   Data and cntl always show slice[owner].
//   WEnable is forced to 0 when not in ST_BUSY, so an idle port is never written.
//  Other requesters' req is ignored during ST_BUSY. There is no preemption.
//  Simultaneous release by the owner and a new req from another requester:
//   release wins. The new grant comes two cycles later, via ST_IDLE.
//  req[owner] dropping and re-rising in the release cycle still costs one idle cycle.
//  Async reset mid-grant: gnt drops immediately and the FSM restarts at ST_START.
//  gnt is always one-hot or zero. Assert this in simulation.
// CONFIGURATION
//  SC_TX_ARB_HOLD_TIMEOUT_EN defined:
//   hold_cnt ($clog2(HOLD_MAX+1) bits) clears on grant and increments in ST_BUSY.
//   When hold_cnt reaches HOLD_MAX: force gnt = 0 and state = ST_IDLE.
//   In the same cycle, pulse hold_err for 1 cycle.
//   In RR mode the offender goes last. Fixed mode gives it no penalty.
//  Undefined: no counter; hold_err tied to 0; grants are held indefinitely.
// STRUCTURE
//  Package sc_tx_arb_pkg:
//   state enum (ST_START, ST_IDLE, ST_BUSY)
//   ARB_FIXED = 0, ARB_RR = 1
//   function onehot(idx, n)
//  Sub-module sc_arb_pick:
//   combinational, parameter NUM_REQ.
//   Inputs: req, start_ptr. Outputs: valid, winner index.
//   Fixed mode drives start_ptr = 0.
//  Top level holds the FSM, owner/rr_ptr/hold_cnt registers and the output mux.
// TESTING
//  1. Reset release, req=3'b011, fixed mode:
//     gnt=0 in ST_START; gnt=3'b001 one cycle after ST_IDLE.
//     SCTxPortData = data[0].
//  2. Owner 0 drops req while req[1] is held:
//     gnt 001 -> 000 (1 cycle) -> 010. WEnable = 0 during the gap cycle.
//  3. RR mode, req=3'b111 held, each owner releases after 4 cycles:
//     grant order 0,1,2,0. rr_ptr wraps 2 -> 0.
//  4. Assert rst mid-grant (gnt=3'b010):
//     gnt=0 asynchronously, before the next clk edge. ST_START precedes any regrant.
//  5. Macro on, HOLD_MAX=8, req[0] held forever, req[1]=1, RR mode:
//     after 8 busy cycles hold_err pulses and gnt=0; next grant = 010.
//  6. Idle with wen[owner]=1:
//     SCTxPortWEnable stays 0. SCTxPortRdyOut follows SCTxPortRdyIn in the same cycle.

Source files
------------

// File: rtl/sc_tx_arb_pkg.sv
// Shared types and helpers for the SCTxPort arbiter.
// The optional hold timeout in sc_tx_port_arb_n is enabled by SC_TX_ARB_HOLD_TIMEOUT_EN.
package sc_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int MAX_REQ   = 8;

    function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
        onehot = '0;
        if (idx >= 0 && idx < n && idx < MAX_REQ) begin
            onehot = MAX_REQ'(1) << idx;
        end
    endfunction

endpackage

// File: rtl/sc_arb_pick.sv
// Combinational winner search: first set req at or after start_ptr, modulo NUM_REQ.
module sc_arb_pick #(
    parameter int NUM_REQ = 3,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      start_ptr,
    output logic               valid,
    output logic [PW-1:0]      winner
);

    // Scan from the farthest offset down so the nearest set request is written last.
    always_comb begin
        int idx;
        idx    = 0;
        valid  = |req;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(start_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) winner = PW'(idx);
        end
    end

endmodule

// File: rtl/sc_tx_port_arb_n.sv
// N-way arbiter and mux for the slave-controller TX port, fixed-priority or round-robin.
// Define SC_TX_ARB_HOLD_TIMEOUT_EN to add the grant-hold timeout and hold_err pulse.
module sc_tx_port_arb_n
    import sc_tx_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int HOLD_MAX = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        wen,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    input  logic [NUM_REQ*DATA_W-1:0] cntl,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      SCTxPortRdyIn,
    output logic                      SCTxPortRdyOut,
    output logic                      SCTxPortWEnable,
    output logic [DATA_W-1:0]         SCTxPortData,
    output logic [DATA_W-1:0]         SCTxPortCntl,
    output logic                      hold_err
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || HOLD_MAX < 1) begin : g_bad_param
        $error("sc_tx_port_arb_n: parameter out of range");
    end

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 hold_err_q, hold_err_d;
    logic                 grant_go;
    logic                 timeout;
    logic                 pick_valid;
    logic [PW-1:0]        pick_w;
    logic [PW-1:0]        start_ptr;
    logic [MAX_REQ-1:0]   oh_full;

    assign start_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    sc_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req       (req),
        .start_ptr (start_ptr),
        .valid     (pick_valid),
        .winner    (pick_w)
    );

`ifdef SC_TX_ARB_HOLD_TIMEOUT_EN
    localparam int HCW = $clog2(HOLD_MAX + 1);
    logic [HCW-1:0] hold_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= '0;
        end else if (grant_go) begin
            hold_cnt_q <= '0;
        end else if (state_q == ST_BUSY && hold_cnt_q != HCW'(HOLD_MAX)) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    // Fires on the last permitted busy cycle so the grant spans exactly HOLD_MAX cycles.
    assign timeout = (state_q == ST_BUSY) && (hold_cnt_q == HCW'(HOLD_MAX - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_START;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_err_q <= hold_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_err_d = 1'b0;
        grant_go   = 1'b0;
        oh_full    = onehot(int'(pick_w), NUM_REQ);
        unique case (state_q)
            ST_START: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d  = ST_BUSY;
                    gnt_d    = oh_full[NUM_REQ-1:0];
                    owner_d  = pick_w;
                    grant_go = 1'b1;
                    if (ARB_MODE == ARB_RR) begin
                        rr_ptr_d = (pick_w == PW'(NUM_REQ - 1)) ? '0 : pick_w + 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (timeout) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    hold_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_START;
                gnt_d   = '0;
            end
        endcase
    end

    assign gnt             = gnt_q;
    assign hold_err        = hold_err_q;
    assign SCTxPortRdyOut  = SCTxPortRdyIn;
    assign SCTxPortWEnable = wen[owner_q] & (state_q == ST_BUSY);
    assign SCTxPortData    = data[int'(owner_q)*DATA_W +: DATA_W];
    assign SCTxPortCntl    = cntl[int'(owner_q)*DATA_W +: DATA_W];

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_sc_tx_port_arb_n.sv
// Self-checking bench for sc_tx_port_arb_n: one fixed-priority and one round-robin instance.
module tb_sc_tx_port_arb_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Fixed-priority instance
    logic [2:0]  req_f = '0, wen_f = '0, gnt_f;
    logic [23:0] data_f = {8'hC2, 8'hB1, 8'hA0};
    logic [23:0] cntl_f = {8'h32, 8'h21, 8'h10};
    logic        rdy_f = 1'b0, rdyo_f, we_f, herr_f;
    logic [7:0]  pd_f, pc_f;

    // Round-robin instance
    logic [2:0]  req_r = '0, wen_r = '0, gnt_r;
    logic [23:0] data_r = {8'h5C, 8'h5B, 8'h5A};
    logic [23:0] cntl_r = {8'h6C, 8'h6B, 8'h6A};
    logic        rdy_r = 1'b0, rdyo_r, we_r, herr_r;
    logic [7:0]  pd_r, pc_r;

    sc_tx_port_arb_n #(.NUM_REQ(3), .DATA_W(8), .ARB_MODE(0), .HOLD_MAX(64)) dut_f (
        .clk(clk), .rst(rst_n), .req(req_f), .wen(wen_f), .data(data_f), .cntl(cntl_f),
        .gnt(gnt_f), .SCTxPortRdyIn(rdy_f), .SCTxPortRdyOut(rdyo_f),
        .SCTxPortWEnable(we_f), .SCTxPortData(pd_f), .SCTxPortCntl(pc_f), .hold_err(herr_f)
    );

    sc_tx_port_arb_n #(.NUM_REQ(3), .DATA_W(8), .ARB_MODE(1), .HOLD_MAX(8)) dut_r (
        .clk(clk), .rst(rst_n), .req(req_r), .wen(wen_r), .data(data_r), .cntl(cntl_r),
        .gnt(gnt_r), .SCTxPortRdyIn(rdy_r), .SCTxPortRdyOut(rdyo_r),
        .SCTxPortWEnable(we_r), .SCTxPortData(pd_r), .SCTxPortCntl(pc_r), .hold_err(herr_r)
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] wen;
        logic       rdy;
        logic [2:0] exp_gnt;
        logic       exp_we;
        logic [7:0] exp_data;
        logic [7:0] exp_cntl;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Rows: inputs held across the next edge, outputs expected just after it.
        vecs[0]  = '{3'b011, 3'b011, 1'b1, 3'b000, 1'b0, 8'hA0, 8'h10}; // START -> IDLE
        vecs[1]  = '{3'b011, 3'b011, 1'b0, 3'b001, 1'b1, 8'hA0, 8'h10}; // grant lowest index
        vecs[2]  = '{3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 8'hA0, 8'h10};
        vecs[3]  = '{3'b010, 3'b011, 1'b0, 3'b000, 1'b0, 8'hA0, 8'h10}; // gap, WEn forced 0
        vecs[4]  = '{3'b010, 3'b011, 1'b1, 3'b010, 1'b1, 8'hB1, 8'h21};
        vecs[5]  = '{3'b010, 3'b001, 1'b0, 3'b010, 1'b0, 8'hB1, 8'h21}; // owner wen low
        vecs[6]  = '{3'b101, 3'b111, 1'b1, 3'b000, 1'b0, 8'hB1, 8'h21}; // release wins
        vecs[7]  = '{3'b101, 3'b111, 1'b0, 3'b001, 1'b1, 8'hA0, 8'h10};
        vecs[8]  = '{3'b100, 3'b111, 1'b1, 3'b000, 1'b0, 8'hA0, 8'h10};
        vecs[9]  = '{3'b100, 3'b111, 1'b0, 3'b100, 1'b1, 8'hC2, 8'h32};
        vecs[10] = '{3'b000, 3'b111, 1'b1, 3'b000, 1'b0, 8'hC2, 8'h32}; // owner held while idle
        vecs[11] = '{3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 8'hC2, 8'h32};
        vecs[12] = '{3'b100, 3'b100, 1'b1, 3'b100, 1'b1, 8'hC2, 8'h32};
        vecs[13] = '{3'b000, 3'b100, 1'b0, 3'b000, 1'b0, 8'hC2, 8'h32};
        vecs[14] = '{3'b100, 3'b100, 1'b1, 3'b100, 1'b1, 8'hC2, 8'h32};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt_f), 32'h0);
        chk("reset_data_owner0", 32'(pd_f), 32'hA0);
        chk("reset_we", 32'(we_f), 32'h0);
        rst_n = 1'b1;
        chk("start_gnt", 32'(gnt_f), 32'h0);
        chk("start_hold_err", 32'(herr_f), 32'h0);

        for (int i = 0; i < 15; i++) begin
            req_f = vecs[i].req;
            wen_f = vecs[i].wen;
            rdy_f = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_gnt", i), 32'(gnt_f), 32'(vecs[i].exp_gnt));
            chk($sformatf("vec%0d_we", i), 32'(we_f), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_data", i), 32'(pd_f), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_cntl", i), 32'(pc_f), 32'(vecs[i].exp_cntl));
            chk($sformatf("vec%0d_rdy", i), 32'(rdyo_f), 32'(vecs[i].rdy));
        end

        // Ready pass-through within the same cycle, away from any edge
        #2 rdy_f = 1'b0;
        #1 chk("rdy_passthru_lo", 32'(rdyo_f), 32'h0);
        rdy_f = 1'b1;
        #1 chk("rdy_passthru_hi", 32'(rdyo_f), 32'h1);

        // Async reset mid-grant
        req_f = 3'b000;
        tick();
        req_f = 3'b010;
        tick();
        chk("pre_reset_gnt", 32'(gnt_f), 32'h2);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_gnt", 32'(gnt_f), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("after_reset_start_gnt", 32'(gnt_f), 32'h0);
        tick();
        chk("after_reset_idle_gnt", 32'(gnt_f), 32'h0);
        tick();
        chk("regrant_gnt", 32'(gnt_f), 32'h2);
        req_f = 3'b000;

        // Round-robin: each owner holds for 4 cycles, order 0,1,2,0
        begin
            int order[4] = '{0, 1, 2, 0};
            req_r = 3'b111;
            wen_r = 3'b111;
            for (int g = 0; g < 4; g++) begin
                int n;
                logic [2:0] exp_g;
                n = 0;
                exp_g = 3'b001 << order[g];
                tick();
                while (gnt_r == 3'b000 && n < 4) begin
                    tick();
                    n++;
                end
                chk($sformatf("rr_grant%0d", g), 32'(gnt_r), 32'(exp_g));
                chk($sformatf("rr_data%0d", g), 32'(pd_r), 32'(8'h5A + 8'(order[g])));
                for (int c = 1; c < 4; c++) begin
                    tick();
                    chk($sformatf("rr_hold%0d_%0d", g, c), 32'(gnt_r), 32'(exp_g));
                end
                req_r[order[g]] = 1'b0;
                tick();
                chk($sformatf("rr_release%0d", g), 32'(gnt_r), 32'h0);
                req_r[order[g]] = 1'b1;
            end
            req_r = 3'b000;
            tick();
        end

        // Hold timeout: restart so rr_ptr is 0, then req[0] never releases
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req_r = 3'b011;
        tick();
        chk("to_first_grant", 32'(gnt_r), 32'h1);
`ifdef SC_TX_ARB_HOLD_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk($sformatf("to_busy%0d_gnt", c), 32'(gnt_r), 32'h1);
            chk($sformatf("to_busy%0d_err", c), 32'(herr_r), 32'h0);
        end
        tick();
        chk("to_expire_gnt", 32'(gnt_r), 32'h0);
        chk("to_expire_err", 32'(herr_r), 32'h1);
        tick();
        chk("to_next_gnt", 32'(gnt_r), 32'h2);
        chk("to_err_pulse_end", 32'(herr_r), 32'h0);
`else
        for (int c = 2; c <= 20; c++) begin
            tick();
            chk($sformatf("hold_c%0d_gnt", c), 32'(gnt_r), 32'h1);
            chk($sformatf("hold_c%0d_err", c), 32'(herr_r), 32'h0);
        end
`endif
        req_r = 3'b000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
